dtc_class_vote: RTL

Sequential post-processing stage that sits directly downstream of the decision-tree classifier cores. It consumes the 3-bit class prediction produced per feature vector, accumulates a per-class histogram over a fixed window of valid predictions, then reduces the histogram to a single majority-vote class. The result is presented on a valid/ready output port. It smooths single-sample misclassifications before results leave the classifier subsystem.

---
 rtl/dtc_class_vote_if.sv | 25 ++
 rtl/dtc_class_vote.sv | 116 +++++++++++
 2 files changed

// File: rtl/dtc_class_vote_if.sv
// Handshake bundle between the classifier cores, the vote stage and its consumer.
// The prediction side uses in_valid/in_ready; the result side uses out_valid/out_ready.
// The master modport belongs to the upstream/downstream environment, the slave modport to the vote stage.
interface dtc_class_vote_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_class;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_class;
  logic [CNT_W-1:0] out_count;
  logic             out_tie;

  modport master (
    output in_valid, in_class, out_ready,
    input  in_ready, out_valid, out_class, out_count, out_tie
  );

  modport slave (
    input  in_valid, in_class, out_ready,
    output in_ready, out_valid, out_class, out_count, out_tie
  );
endinterface

// File: rtl/dtc_class_vote.sv
// Majority vote over a window of WINDOW class predictions (8 classes, lowest index wins ties).
// Latency: result valid 8 edges after the edge accepting the last sample (transition + 8-class scan).
// Backpressure: in_ready low during scan and while the result waits for out_ready; nothing is dropped.
module dtc_class_vote #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input logic             clk,
  input logic             rst,
  dtc_class_vote_if.slave bus
);

  typedef enum logic [1:0] {ACCUM, REDUCE, HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW);

  state_t           state;
  logic [CNT_W-1:0] cnt [8];
  logic [CNT_W-1:0] sample_cnt;
  logic [2:0]       idx;
  logic [CNT_W-1:0] max_q;
  logic [2:0]       win_q;
  logic             tie_q;

  logic [CNT_W-1:0] scan_max;
  logic [2:0]       scan_win;
  logic             scan_tie;

  logic             out_valid_q;
  logic [2:0]       out_class_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_tie_q;

  logic             accept;

  // Ready is gated by reset so upstream never sees ready while state is being cleared.
  assign bus.in_ready  = (state == ACCUM) & ~rst;
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_count = out_count_q;
  assign bus.out_tie   = out_tie_q;

  // Next running max/winner/tie after examining class idx; index 0 seeds the scan.
  always_comb begin
    scan_max = max_q;
    scan_win = win_q;
    scan_tie = tie_q;
    if (idx == 3'd0) begin
      scan_max = cnt[0];
      scan_win = 3'd0;
      scan_tie = 1'b0;
    end else if (cnt[idx] > max_q) begin
      scan_max = cnt[idx];
      scan_win = idx;
      scan_tie = 1'b0;
    end else if (cnt[idx] == max_q) begin
      scan_tie = 1'b1;
    end
  end

  // Accumulate histogram, scan it one class per cycle, then hold the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      sample_cnt  <= '0;
      idx         <= 3'd0;
      max_q       <= '0;
      win_q       <= 3'd0;
      tie_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= 3'd0;
      out_count_q <= '0;
      out_tie_q   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            cnt[bus.in_class] <= cnt[bus.in_class] + ONE;
            sample_cnt        <= sample_cnt + ONE;
            if (sample_cnt + ONE == LAST) begin
              state <= REDUCE;
              idx   <= 3'd0;
            end
          end
        end
        REDUCE: begin
          max_q <= scan_max;
          win_q <= scan_win;
          tie_q <= scan_tie;
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
            out_class_q <= scan_win;
            out_count_q <= scan_max;
            out_tie_q   <= scan_tie;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            sample_cnt  <= '0;
            out_valid_q <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
